axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI3 responder backed by an on-chip word-addressed SRAM; it is the far end of the core's AXI master port.
- Used as the boot/data memory in core-level simulation and in FPGA bring-up tops.
- Serves one read burst and one write burst concurrently, with independent read and write state machines.
- Supports FIXED and INCR bursts of 1–16 beats with byte strobes, and returns SLVERR for unsupported or out-of-range accesses.

Parameters:
- ID_W, 4, width of arid/rid/awid/wid/bid.
- ADDR_W, 32, AXI address width.
- DEPTH_LOG2, 14, log2 of memory depth in 32-bit words (64 KiB).
- BASE_ADDR, 32'h1c00_0000, byte address of word 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/4/3/2  write address
- awlock/awcache/awprot  in  2/4/3  accepted and ignored
- awvalid  in  1;  awready  out  1
- wid/wdata/wstrb/wlast/wvalid  in  ID_W/32/4/1/1;  wready  out  1
- bid/bresp  out  ID_W/2;  bvalid  out  1;  bready  in  1
- arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/4/3/2  read address
- arlock/arcache/arprot  in  2/4/3  ignored
- arvalid  in  1;  arready  out  1
- rid/rdata/rresp/rlast  out  ID_W/32/2/1;  rvalid  out  1;  rready  in  1

Behaviour:
- Reset (clk edge with reset=1):
  - Both FSMs return to IDLE.
  - arready, awready, wready, rvalid, bvalid, rlast = 0; rdata, rresp, rid, bid, bresp = 0.
  - Memory contents are preserved, including when reset hits mid-burst.
  - In-flight bursts are abandoned with no response.
- Read FSM, R_IDLE -> R_DATA:
  - arready = 1 only in R_IDLE; a handshake latches id, addr, len, size, burst and sets beat count to 0.
  - rvalid rises the cycle after the AR handshake (1-cycle latency).
  - rdata = mem[word index of current address].
  - Each beat advances on rvalid&rready. rlast = 1 on beat len.
  - The beat handshaken with rlast returns to R_IDLE; arready is back to 1 on the next cycle.
  - rid, rresp, rdata, rlast are held stable while rvalid=1 and rready=0.
- Address arithmetic:
  - Word index = (addr - BASE_ADDR) >> 2.
  - INCR: addr += (1 << size) after each beat, in ADDR_W-bit modular arithmetic.
  - FIXED: addr is not updated.
  - Narrow transfers return the full word; the master selects byte lanes.
- Error / OKAY rules:
  - Error = burst==WRAP(2'b10) or reserved(2'b11), OR size>2, OR current address outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2).
  - An erroring read beat returns rresp=2'b10 (SLVERR) and rdata=0, but still counts as a beat.
  - Range is checked per beat, so a burst running off the end returns OKAY beats then SLVERR beats.
  - Non-error beats return rresp=2'b00.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - awready = 1 only in W_IDLE.
  - wready = 1 only in W_DATA, starting the cycle after the AW handshake.
  - A master holding wvalid together with awvalid is legal; its data is taken in W_DATA.
  - Each W handshake writes the wdata bytes enabled by wstrb[i] to the current word, unless the beat errors or beat count > len.
  - Address advance follows the read rules.
  - wid is ignored.
- Write completion:
  - The W handshake with wlast=1 moves to W_RESP; bvalid rises the next cycle with bid = latched awid.
  - bresp = SLVERR if any beat errored OR the number of accepted beats != len+1; otherwise OKAY.
  - bvalid, bid, bresp are held until bready; then W_IDLE.
- Concurrency:
  - Read and write run fully independently.
  - A same-cycle read and write to the same word: the read returns the old data (write lands at the clock edge; the read samples the pre-edge array for a beat presented that cycle).
- Only one outstanding transaction per direction.
- No X may propagate on outputs after reset.

Test Plan:
- Single read: AR handshake with araddr=0x1c00_0010, arlen=0, arid=3, mem[4]=0xDEADBEEF.
  -> rvalid one cycle later with rdata=0xDEADBEEF, rid=3, rresp=0, rlast=1; arready back to 1 after the R handshake.
- Write then read back: AW+W presented together (addr 0x1c00_0020, wdata 0x11223344, wstrb 4'b0101, wlast=1) over old contents 0xAABBCCDD.
  -> bvalid with bresp=0, bid=awid; a subsequent read returns 0xAA22CC44.
- INCR burst of 4 with rready toggled every other cycle.
  -> 4 beats from consecutive words; data is stable while stalled; rlast only on beat 4.
- Write burst awlen=3 where the master asserts wlast on beat 2.
  -> 2 words written, bresp=2'b10.
- Out of range: araddr=BASE_ADDR+0x1_0000-4, arlen=1, INCR.
  -> beat 1 OKAY with data; beat 2 rresp=2'b10, rdata=0.
- Reset asserted on beat 2 of a 4-beat read while a write sits in W_RESP.
  -> next cycle rvalid=bvalid=0 and arready=awready=1; memory unchanged.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed on-chip SRAM; one read burst and one
// write burst in flight at a time, served by independent FSMs.
module axi_sram_slave #(
  parameter int                ID_W       = 4,
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH_LOG2 = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h1c00_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready
);
  localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;
  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } burst_t;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic unused_ok;
  assign unused_ok = ^{awlock, awcache, awprot, arlock, arcache, arprot, wid};

  // WRAP/reserved bursts, >32-bit beats and out-of-window addresses all error.
  function automatic logic beat_err(input logic [ADDR_W-1:0] a, input logic [2:0] sz,
                                    input logic [1:0] bt);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return bt[1] | (sz > 3'd2) | (off[ADDR_W-1:DEPTH_LOG2+2] != '0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] widx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return off[DEPTH_LOG2+1:2];
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input burst_t b);
    return (b.burst == 2'b00) ? b.addr : b.addr + (ADDR_W'(1) << b.size);
  endfunction

  // ---------------- read path ----------------
  logic [0:0]        rstate;
  burst_t            rb;
  logic [3:0]        rbeat;
  logic              ar_err, rn_err;
  logic [ADDR_W-1:0] rn_addr;

  assign rid     = rb.id;
  assign ar_err  = beat_err(araddr, arsize, arburst);
  assign rn_addr = next_addr(rb);
  assign rn_err  = beat_err(rn_addr, rb.size, rb.burst);

  // rdata is registered when a beat is presented, so it reads the array as it
  // stood before any write landing on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rstate  <= R_IDLE;
      rb      <= '0;
      rbeat   <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (arvalid && arready) begin
            rb      <= '{arid, araddr, arlen, arsize, arburst};
            rbeat   <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rlast   <= (arlen == 4'd0);
            rresp   <= ar_err ? SLVERR : OKAY;
            rdata   <= ar_err ? '0 : mem[widx(araddr)];
            rstate  <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        default: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              rstate  <= R_IDLE;
            end else begin
              rb.addr <= rn_addr;
              rbeat   <= rbeat + 4'd1;
              rlast   <= (rbeat + 4'd1 == rb.len);
              rresp   <= rn_err ? SLVERR : OKAY;
              rdata   <= rn_err ? '0 : mem[widx(rn_addr)];
            end
          end
        end
      endcase
    end
  end

  // ---------------- write path ----------------
  logic [1:0] wstate;
  burst_t     wb;
  logic [4:0] wbeat;
  logic       werr, w_err, w_fire, mem_we;

  assign w_err  = beat_err(wb.addr, wb.size, wb.burst);
  assign w_fire = (wstate == W_DATA) && wvalid && wready;
  assign mem_we = w_fire && !w_err && (wbeat <= {1'b0, wb.len});

  always_ff @(posedge clk) begin
    if (!reset && mem_we)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[widx(wb.addr)][8*i +: 8] <= wdata[8*i +: 8];
  end

  // wbeat saturates so an over-long burst still reports a beat-count mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      wstate  <= W_IDLE;
      wb      <= '0;
      wbeat   <= '0;
      werr    <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= OKAY;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (awvalid && awready) begin
            wb      <= '{awid, awaddr, awlen, awsize, awburst};
            wbeat   <= '0;
            werr    <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            wstate  <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            wb.addr <= next_addr(wb);
            wbeat   <= (wbeat == 5'd31) ? wbeat : wbeat + 5'd1;
            werr    <= werr | w_err;
            if (wlast) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= wb.id;
              bresp  <= (werr || w_err || wbeat != {1'b0, wb.len}) ? SLVERR : OKAY;
              wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a word-array model predicts every R beat
// and B response; a negedge monitor compares them and checks stall stability.
module tb_axi_sram_slave;
  localparam logic [31:0] BASE = 32'h1c00_0000;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  awid, wid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen, awcache, arcache, wstrb;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, awlock, arlock, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;

  axi_sram_slave dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_checks = 0, n_fail = 0;
  logic [38:0] rq [$];   // {id, data, resp, last}
  logic [5:0]  bq [$];   // {id, resp}
  logic [33:0] rlog [$]; // {resp, data}
  logic [5:0]  blog [$];
  logic [31:0] mm [0:16383];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        r_hold = 1'b0, b_hold = 1'b0;
  logic [38:0] r_snap;
  logic [5:0]  b_snap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake timed out", name);
  endtask

  function automatic bit m_err(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bt);
    return (bt >= 2'd2) || (sz > 3'd2) || ((a - BASE) >= 32'h1_0000);
  endfunction

  function automatic void model_read(input logic [3:0] id, input logic [31:0] addr,
      input logic [3:0] len, input logic [2:0] sz, input logic [1:0] bt);
    logic [31:0] a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      bit e = m_err(a, sz, bt);
      rq.push_back({id, e ? 32'h0 : mm[(a - BASE) >> 2], e ? 2'b10 : 2'b00, b == int'(len)});
      if (bt == 2'd1) a = a + (32'd1 << sz);
    end
  endfunction

  function automatic void model_write(input logic [3:0] id, input logic [31:0] addr,
      input logic [3:0] len, input logic [2:0] sz, input logic [1:0] bt, input int nb);
    logic [31:0] a = addr;
    bit any_err = 0;
    for (int b = 0; b < nb; b++) begin
      bit e = m_err(a, sz, bt);
      any_err |= e;
      if (!e && b <= int'(len))
        for (int i = 0; i < 4; i++)
          if (ws[b][i]) mm[(a - BASE) >> 2][8*i +: 8] = wd[b][8*i +: 8];
      if (bt == 2'd1) a = a + (32'd1 << sz);
    end
    bq.push_back({id, (any_err || nb != int'(len) + 1) ? 2'b10 : 2'b00});
  endfunction

  // Monitor: compares each handshaken beat and checks stalled outputs hold.
  always @(negedge clk) begin
    if (reset) begin
      r_hold = 1'b0;
      b_hold = 1'b0;
    end else begin
      if (r_hold) chk("r_stable", {rvalid, rid, rdata, rresp, rlast}, {1'b1, r_snap});
      if (b_hold) chk("b_stable", {bvalid, bid, bresp}, {1'b1, b_snap});
      if (rvalid && rready) begin
        if (rq.size() == 0) tmo("r_unexpected_beat");
        else chk("r_beat", {rid, rdata, rresp, rlast}, rq.pop_front());
        rlog.push_back({rresp, rdata});
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) tmo("b_unexpected_resp");
        else chk("b_resp", {bid, bresp}, bq.pop_front());
        blog.push_back({bid, bresp});
      end
      r_hold = rvalid && !rready;
      r_snap = {rid, rdata, rresp, rlast};
      b_hold = bvalid && !bready;
      b_snap = {bid, bresp};
    end
  end

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
      input logic [2:0] sz, input logic [1:0] bt, input bit toggle);
    int n;
    bit done;
    model_read(id, addr, len, sz, bt);
    arid = id; araddr = addr; arlen = len; arsize = sz; arburst = bt; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin tmo("ar_handshake"); arvalid = 1'b0; return; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = !toggle;
    @(negedge clk);
    chk("r_latency", rvalid, 1);
    done = 0; n = 0;
    while (!done && n < 100) begin
      if (rvalid && rready && rlast) done = 1;
      @(posedge clk); #1;
      if (toggle) rready = !rready;
      n++;
      if (!done) @(negedge clk);
    end
    rready = 1'b0;
    if (!done) tmo("r_last");
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
      input logic [2:0] sz, input logic [1:0] bt, input int nb, input bit together, input bit skip_b);
    int n;
    model_write(id, addr, len, sz, bt, nb);
    awid = id; awaddr = addr; awlen = len; awsize = sz; awburst = bt; awvalid = 1'b1;
    if (together) begin
      wdata = wd[0]; wstrb = ws[0]; wlast = (nb == 1); wvalid = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin tmo("aw_handshake"); awvalid = 1'b0; wvalid = 1'b0; return; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == nb - 1); wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) begin tmo("w_handshake"); break; end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = !skip_b;
    @(negedge clk);
    chk("b_latency", bvalid, 1);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  initial begin
    int n;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 0; awcache = 0; awprot = 0;
    awvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 0; arcache = 0; arprot = 0;
    arvalid = 0; rready = 0;
    for (int i = 0; i < 16384; i++) mm[i] = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {arready, awready, wready, rvalid, bvalid, rlast, rdata, rresp, rid, bid, bresp}, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", {arready, awready, wready, rvalid, bvalid}, 5'b11000);

    // preload words 0..15 and the last word
    for (int i = 0; i < 16; i++) begin wd[i] = 32'hA5A5_0000 | i; ws[i] = 4'hF; end
    wd[4] = 32'hDEAD_BEEF; wd[8] = 32'hAABB_CCDD;
    do_write(4'd1, BASE, 4'd15, 3'd2, 2'd1, 16, 1'b0, 1'b0);
    wd[0] = 32'hCAFE_F00D;
    do_write(4'd2, BASE + 32'hFFFC, 4'd0, 3'd2, 2'd1, 1, 1'b1, 1'b0);

    rlog.delete();
    do_read(4'd3, 32'h1c00_0010, 4'd0, 3'd2, 2'd1, 1'b0);
    chk("arready_back", arready, 1);
    chk("lit_deadbeef", rlog[0], {2'b00, 32'hDEAD_BEEF});

    wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
    do_write(4'd5, 32'h1c00_0020, 4'd0, 3'd2, 2'd1, 1, 1'b1, 1'b0);
    chk("lit_bresp_okay", blog[blog.size()-1], {4'd5, 2'b00});
    rlog.delete();
    do_read(4'd6, 32'h1c00_0020, 4'd0, 3'd2, 2'd1, 1'b0);
    chk("lit_strobe_merge", rlog[0], {2'b00, 32'hAA22_CC44});

    rlog.delete();
    do_read(4'd7, BASE + 32'h10, 4'd3, 3'd2, 2'd1, 1'b1);
    chk("lit_incr_beat4", rlog[3], {2'b00, 32'hA5A5_0007});

    wd[0] = 32'h5555_0000; wd[1] = 32'h5555_1111; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(4'd8, BASE + 32'h30, 4'd3, 3'd2, 2'd1, 2, 1'b0, 1'b0);
    chk("lit_short_burst_slverr", blog[blog.size()-1], {4'd8, 2'b10});
    rlog.delete();
    do_read(4'd9, BASE + 32'h30, 4'd3, 3'd2, 2'd1, 1'b0);
    chk("lit_short_written", rlog[1], {2'b00, 32'h5555_1111});
    chk("lit_short_untouched", rlog[2], {2'b00, 32'hA5A5_000E});

    rlog.delete();
    do_read(4'd10, BASE + 32'hFFFC, 4'd1, 3'd2, 2'd1, 1'b0);
    chk("lit_oor_beat1", rlog[0], {2'b00, 32'hCAFE_F00D});
    chk("lit_oor_beat2", rlog[1], {2'b10, 32'h0});

    do_read(4'd11, BASE + 32'h10, 4'd2, 3'd2, 2'd0, 1'b0);  // FIXED
    do_read(4'd12, BASE + 32'h10, 4'd0, 3'd2, 2'd2, 1'b0);  // WRAP -> SLVERR
    do_read(4'd13, BASE + 32'h10, 4'd0, 3'd3, 2'd1, 1'b0);  // size 3 -> SLVERR
    do_read(4'd4, BASE + 32'h10, 4'd1, 3'd0, 2'd1, 1'b0);   // narrow INCR
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    do_write(4'd14, BASE + 32'h10, 4'd0, 3'd3, 2'd1, 1, 1'b0, 1'b0);
    rlog.delete();
    do_read(4'd0, BASE + 32'h10, 4'd0, 3'd2, 2'd1, 1'b0);
    chk("lit_err_write_dropped", rlog[0], {2'b00, 32'hDEAD_BEEF});

    // reset mid read burst while a write response waits for bready
    wd[0] = 32'h0BAD_F00D; ws[0] = 4'hF;
    do_write(4'd15, BASE + 32'h4, 4'd0, 3'd2, 2'd1, 1, 1'b1, 1'b1);
    model_read(4'd1, BASE, 4'd3, 3'd2, 2'd1);
    arid = 4'd1; araddr = BASE; arlen = 4'd3; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) tmo("ar_handshake_rst");
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    rq.delete(); bq.delete();
    chk("rst_mid_valids", {rvalid, bvalid}, 2'b00);
    @(posedge clk); #1;
    chk("rst_mid_ready", {arready, awready}, 2'b11);
    rlog.delete();
    do_read(4'd2, BASE, 4'd3, 3'd2, 2'd1, 1'b0);
    chk("lit_mem_kept", rlog[1], {2'b00, 32'h0BAD_F00D});

    repeat (5) @(posedge clk);
    chk("r_drained", rq.size(), 0);
    chk("b_drained", bq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
